// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main-memory responder: default geometry and FSM encoding.
package main_memory_responder_pkg;

    localparam int unsigned DEF_LINE_WORDS  = 4;
    localparam int unsigned DEF_LATENCY     = 4;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;

    localparam int unsigned BUS_W      = 32;
    localparam int unsigned BYTE_OFS_W = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WAIT     = 3'd2,
        RD_BURST = 3'd3,
        WR_ACK   = 3'd4
    } respState_t;

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-side bus between a line requester (master) and the memory responder (slave).
interface main_memory_responder_if;
    import main_memory_responder_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [BUS_W-1:0] req_addr;
    logic             wr_valid;
    logic             wr_ready;
    logic [BUS_W-1:0] wr_data;
    logic             resp_valid;
    logic [BUS_W-1:0] resp_data;
    logic             resp_last;
    logic             wr_done;

    modport master (
        output req_valid, req_write, req_addr, wr_valid, wr_data,
        input  req_ready, wr_ready, resp_valid, resp_data, resp_last, wr_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, wr_valid, wr_data,
        output req_ready, wr_ready, resp_valid, resp_data, resp_last, wr_done
    );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word store: synchronous write, combinational read, never cleared by reset.
module mem_word_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             writeEn,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] readData
);

    logic [WIDTH-1:0] words [DEPTH];

    always_ff @(posedge clock) begin
        if (writeEn) begin
            words[addr] <= writeData;
        end
    end

    assign readData = words[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Line-granular memory model: accepts refill/write-back requests, delays by LATENCY and
// streams or absorbs one cache line per transaction.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input logic                    clock,
    input logic                    reset,
    main_memory_responder_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam int unsigned LINE_W = ADDR_W - BEAT_W;
    localparam int unsigned LAT_W  = $clog2(LATENCY + 1);
    localparam int unsigned IDX_LO = BEAT_W + BYTE_OFS_W;
    localparam int unsigned IDX_HI = ADDR_W + BYTE_OFS_W - 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(LATENCY - 1);

    respState_t        state;
    respState_t        nextState;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] nextBeat;
    logic [LAT_W-1:0]  latCnt;
    logic [LAT_W-1:0]  nextLatCnt;
    logic [LINE_W-1:0] lineIdx;
    logic              isWrite;
    logic              accept;
    logic              memWe;
    logic [BEAT_W-1:0] memBeat;
    logic [ADDR_W-1:0] memAddr;
    logic [BUS_W-1:0]  memRdata;

    logic              reqReady_c;
    logic              wrReady_c;
    logic              respValid_c;
    logic [BUS_W-1:0]  respData_c;
    logic              respLast_c;
    logic              wrDone_c;

    // Byte offset and bits above the array size are intentionally dropped (address wrap).
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.req_addr[BUS_W-1:IDX_HI+1], bus.req_addr[IDX_LO-1:0]};

    assign accept = (state == IDLE) && bus.req_valid;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and counter logic
    always_comb begin
        nextState  = state;
        nextBeat   = beat;
        nextLatCnt = latCnt;
        memWe      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    nextState  = bus.req_write ? WR_DATA : WAIT;
                    nextBeat   = '0;
                    nextLatCnt = '0;
                end
            end
            WR_DATA: begin
                if (bus.wr_valid) begin
                    memWe = reset;
                    if (beat == LAST_BEAT) begin
                        nextState = WAIT;
                        nextBeat  = '0;
                    end else begin
                        nextBeat = beat + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (latCnt == LAST_WAIT) begin
                    nextState  = isWrite ? WR_ACK : RD_BURST;
                    nextLatCnt = '0;
                end else begin
                    nextLatCnt = latCnt + 1'b1;
                end
            end
            RD_BURST: begin
                if (beat == LAST_BEAT) begin
                    nextState = IDLE;
                    nextBeat  = '0;
                end else begin
                    nextBeat = beat + 1'b1;
                end
            end
            WR_ACK: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Counters and latched request fields
    always_ff @(posedge clock) begin
        if (!reset) begin
            beat    <= '0;
            latCnt  <= '0;
            lineIdx <= '0;
            isWrite <= 1'b0;
        end else begin
            beat   <= nextBeat;
            latCnt <= nextLatCnt;
            if (accept) begin
                lineIdx <= bus.req_addr[IDX_HI:IDX_LO];
                isWrite <= bus.req_write;
            end
        end
    end

    // Writes use the current beat; reads prefetch the beat that the output register shows next.
    assign memBeat = (state == WR_DATA) ? beat : nextBeat;
    assign memAddr = {lineIdx, memBeat};

    mem_word_array #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (BUS_W)
    ) u_mem (
        .clock     (clock),
        .writeEn   (memWe),
        .addr      (memAddr),
        .writeData (bus.wr_data),
        .readData  (memRdata)
    );

    // Output decode from the upcoming state so the registered outputs track the state register
    always_comb begin
        reqReady_c  = 1'b0;
        wrReady_c   = 1'b0;
        respValid_c = 1'b0;
        respData_c  = '0;
        respLast_c  = 1'b0;
        wrDone_c    = 1'b0;
        unique case (nextState)
            IDLE:     reqReady_c = 1'b1;
            WR_DATA:  wrReady_c  = 1'b1;
            RD_BURST: begin
                respValid_c = 1'b1;
                respData_c  = memRdata;
                respLast_c  = (nextBeat == LAST_BEAT);
            end
            WR_ACK:   wrDone_c   = 1'b1;
            default:  reqReady_c = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.req_ready  <= 1'b1;
            bus.wr_ready   <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_last  <= 1'b0;
            bus.wr_done    <= 1'b0;
        end else begin
            bus.req_ready  <= reqReady_c;
            bus.wr_ready   <= wrReady_c;
            bus.resp_valid <= respValid_c;
            bus.resp_data  <= respData_c;
            bus.resp_last  <= respLast_c;
            bus.wr_done    <= wrDone_c;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: refill/write-back timing, aliasing, held requests, resets.
module tb_main_memory_responder;

    typedef logic [31:0] line_t [4];

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    main_memory_responder_if bus ();

    main_memory_responder #(
        .LINE_WORDS  (4),
        .LATENCY     (4),
        .DEPTH_WORDS (1024)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkVal("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic writeLine(input logic [31:0] addr, input line_t d, input int gapAfter, input int gapLen);
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkVal("wr_ready_beat", 32'(bus.wr_ready), 32'd1);
            bus.wr_valid = 1'b1;
            bus.wr_data  = d[k];
            @(negedge clock);
            bus.wr_valid = 1'b0;
            bus.wr_data  = 32'hBAD0_0000;
            if (k == gapAfter) begin
                for (int g = 0; g < gapLen; g++) begin
                    checkVal("wr_ready_gap", 32'(bus.wr_ready), 32'd1);
                    @(negedge clock);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkVal("wr_done_early", 32'(bus.wr_done), 32'd0);
            checkVal("wr_ready_wait", 32'(bus.wr_ready), 32'd0);
            @(negedge clock);
        end
        checkVal("wr_done_pulse", 32'(bus.wr_done), 32'd1);
        checkVal("req_ready_ack", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        checkVal("wr_done_clear", 32'(bus.wr_done), 32'd0);
        checkVal("req_ready_after_wr", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic issueRead(input logic [31:0] addr, input bit hold);
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        @(negedge clock);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic expectBurst(input line_t d);
        for (int i = 0; i < 4; i++) begin
            checkVal("lat_valid", 32'(bus.resp_valid), 32'd0);
            checkVal("lat_data", bus.resp_data, 32'd0);
            checkVal("busy_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clock);
        end
        for (int k = 0; k < 4; k++) begin
            checkVal("beat_valid", 32'(bus.resp_valid), 32'd1);
            checkVal("beat_data", bus.resp_data, d[k]);
            checkVal("beat_last", 32'(bus.resp_last), 32'(k == 3));
            checkVal("burst_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clock);
        end
        checkVal("post_valid", 32'(bus.resp_valid), 32'd0);
        checkVal("post_data", bus.resp_data, 32'd0);
        checkVal("post_last", 32'(bus.resp_last), 32'd0);
        checkVal("post_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic readLine(input logic [31:0] addr, input line_t d);
        issueRead(addr, 1'b0);
        expectBurst(d);
    endtask

    line_t lineA;
    line_t lineB;
    line_t lineC;
    line_t lineD;
    line_t lineE;

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        lineA = '{32'h11, 32'h22, 32'h33, 32'h44};
        lineB = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        lineC = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004};
        lineD = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        lineE = '{32'hE0, 32'hE1, 32'hC2, 32'hC3};

        // Reset values
        repeat (2) @(negedge clock);
        reset = 1'b1;
        checkVal("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkVal("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        checkVal("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkVal("rst_resp_data", bus.resp_data, 32'd0);
        checkVal("rst_resp_last", 32'(bus.resp_last), 32'd0);
        checkVal("rst_wr_done", 32'(bus.wr_done), 32'd0);

        // Preload 0x40 and refill it
        writeLine(32'h0000_0040, lineA, -1, 0);
        readLine(32'h0000_0040, lineA);

        // Write-back with a two-cycle gap after beat 1, then refill
        writeLine(32'h0000_0080, lineB, 1, 2);
        readLine(32'h0000_0080, lineB);

        // Aliasing past the array size
        writeLine(32'h0000_1000, lineC, -1, 0);
        readLine(32'h0000_0000, lineC);

        // Request held through a burst is taken in the first IDLE cycle
        issueRead(32'h0000_0040, 1'b1);
        bus.req_addr = 32'h0000_0080;
        expectBurst(lineA);
        @(negedge clock);
        bus.req_valid = 1'b0;
        expectBurst(lineB);

        // Write beats while idle are ignored
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            checkVal("idle_wr_ready", 32'(bus.wr_ready), 32'd0);
            @(negedge clock);
        end
        bus.wr_valid = 1'b0;
        readLine(32'h0000_0080, lineB);

        // Reset on the third read beat aborts the burst
        issueRead(32'h0000_0080, 1'b0);
        repeat (4) @(negedge clock);
        checkVal("pre_abort_beat0", bus.resp_data, 32'hA0);
        repeat (2) @(negedge clock);
        checkVal("pre_abort_beat2", bus.resp_data, 32'hA2);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checkVal("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkVal("abort_resp_data", bus.resp_data, 32'd0);
        checkVal("abort_resp_last", 32'(bus.resp_last), 32'd0);
        checkVal("abort_req_ready", 32'(bus.req_ready), 32'd1);
        readLine(32'h0000_0080, lineB);

        // Reset after two write beats keeps the partial update and never acknowledges
        writeLine(32'h0000_00C0, lineD, -1, 0);
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_00C0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = lineE[k];
            @(negedge clock);
        end
        bus.wr_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checkVal("wabort_wr_ready", 32'(bus.wr_ready), 32'd0);
        checkVal("wabort_req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkVal("wabort_wr_done", 32'(bus.wr_done), 32'd0);
            @(negedge clock);
        end
        readLine(32'h0000_00C0, lineE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter LINE_WORDS, default 4: 32-bit words per cache line, so a line is 16 bytes.
REQ-002 Parameter LATENCY, default 4: cycles from request acceptance to the first read beat or to the write acknowledge.
REQ-003 Parameter DEPTH_WORDS, default 1024: backing array size in words, power of two.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low; sampled on rising edge of clock.
REQ-006 req_valid  input  1  cache miss or write-back request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = line write-back, 0 = line refill.
REQ-009 req_addr  input  32  byte address of line; bits [3:0] ignored.
REQ-010 wr_valid  input  1  write-back data beat present.
REQ-011 wr_ready  output  1  responder accepts write beat.
REQ-012 wr_data  input  32  write-back beat data.
REQ-013 resp_valid  output  1  read beat valid this cycle.
REQ-014 resp_data  output  32  read beat data.
REQ-015 resp_last  output  1  final read beat of line.
REQ-016 wr_done  output  1  one-cycle pulse: write-back committed.

Function
REQ-017 States SHALL be IDLE, WR_DATA, WAIT, RD_BURST, WR_ACK.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on the cycle where req_valid and req_ready are both 1, and req_addr/req_write are latched then.
REQ-019 Line index SHALL be req_addr[log2(DEPTH_WORDS)+1:4]; higher address bits are ignored, giving wrap-around modulo array size.
REQ-020 Refill: IDLE -> WAIT, count LATENCY cycles, -> RD_BURST.
REQ-021 RD_BURST: resp_valid=1 for exactly LINE_WORDS consecutive cycles, beat k = word k of line in ascending order, no backpressure; resp_last=1 on beat LINE_WORDS-1; then -> IDLE.
REQ-022 First read beat SHALL appear LATENCY+1 cycles after the acceptance edge.
REQ-023 Write-back: IDLE -> WR_DATA; wr_ready=1 only in WR_DATA; each wr_valid&&wr_ready beat is written to word k, k ascending from 0.
REQ-024 After beat LINE_WORDS-1: -> WAIT for LATENCY cycles -> WR_ACK; WR_ACK asserts wr_done for one cycle -> IDLE.
REQ-025 Gaps in wr_valid SHALL stall WR_DATA indefinitely without a timeout.
REQ-026 A refill of a line issued after its wr_done SHALL return the written data.
REQ-027 resp_data SHALL be 0 whenever resp_valid=0.
REQ-028 req_valid outside IDLE SHALL be ignored; the requester holds it until accepted.
REQ-029 wr_valid outside WR_DATA SHALL be ignored.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, clear the latency and beat counters, and give req_ready=1, wr_ready=0, resp_valid=0, resp_data=0, resp_last=0, wr_done=0 from the next cycle.
REQ-031 Reset mid-burst SHALL abort the transaction; words already written stay written; array contents are never cleared by reset.

Structure
REQ-032 A shared package SHALL hold the state encoding (3-bit) and the defaults LINE_WORDS, LATENCY, DEPTH_WORDS.
REQ-033 The storage array SHALL be one sub-module, mem_word_array: single port, synchronous write, combinational read, addressed by {line index, beat}.

Verification
REQ-034 Refill of 0x0000_0040 with preloaded words 0x11,0x22,0x33,0x44 -> resp_valid on cycles 5-8 after acceptance, data in that order, resp_last only with 0x44.
REQ-035 Write-back of 0x0000_0080 with 0xA0..0xA3, wr_valid gap of 2 cycles after beat 1 -> wr_done 4 cycles after last beat; a following refill returns 0xA0..0xA3.
REQ-036 Aliasing: write-back to 0x0000_1000 (DEPTH_WORDS=1024), refill of 0x0000_0000 -> same data returned.
REQ-037 req_valid held during RD_BURST -> req_ready=0 throughout, second request accepted in first IDLE cycle.
REQ-038 reset=0 on third beat of RD_BURST -> next cycle resp_valid=0, req_ready=1; a new refill of the same line returns unchanged contents.
REQ-039 reset=0 after 2 write beats -> words 0-1 updated, words 2-3 unchanged, wr_done never pulses.
